seg7_scanner: RTL and testbench

Time-multiplexed 7-segment display driver in the segment7Module design. It sits directly downstream of the clock `Divider`: the divided `CLK_OUT` enters as a scan-rate `TICK` input, and on each rising edge the block advances to the next display digit. Each frame it latches a packed hex word, decodes one nibble per digit to active-low segments, and drives active-low anode enables. A short anode-off guard interval after each digit change suppresses ghosting.

---
 rtl/seg7_scanner.sv | 165 ++++++++++++++++
 tb/tb_seg7_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed 7-segment display driver.
// A divided scan clock (TICK) steps through DIGITS digits. Each frame, the hex
// word and decimal points are latched. Segments and anodes are active-low. After
// each digit change, the anodes stay off for GUARD cycles to suppress ghosting.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scanner #(
  parameter int DIGITS = 4,
  parameter int GUARD  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  output logic [6:0]            SEG,
  output logic                  SEG_DP,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
  localparam logic [3:0]        GUARD_L = 4'(GUARD);
  localparam logic [DIGITS-1:0] ONE     = DIGITS'(1);

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic                s1_q, s2_q, s3_q, rise_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [3:0]          gcnt_q, gcnt_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                wrap;
  logic [IW-1:0]       nxt_idx;
  int unsigned         nxt_u;
  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;
  logic [3:0]          nib;
  logic [6:0]          seg_new;
  logic [DIGITS-1:0]   an_new;

  // Synchronise TICK and register its rising edge. The registered pulse
  // places the digit step three edges after TICK is first sampled high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= TICK;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  // Decode of the digit about to be selected. At wrap, DATA and DP are used
  // directly so that digit 0 shows the frame that is being latched.
  always_comb begin
    wrap     = (idx_q == LAST);
    nxt_idx  = wrap ? '0 : idx_q + 1'b1;
    nxt_u    = 32'(nxt_idx);
    act_data = wrap ? DATA : sh_data_q;
    act_dp   = wrap ? DP : sh_dp_q;
    nib      = act_data[nxt_u*4 +: 4];
    seg_new  = dec(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int unsigned j = 0; j < DIGITS; j++) begin
        if (j >= nxt_u && act_data[j*4 +: 4] != 4'h0) upper_zero = 1'b0;
      end
      // The decimal-point request comes from the active (frame-coherent) DP.
      if (nxt_u != 0 && upper_zero && !act_dp[nxt_idx]) seg_new = '1;
    end
`endif
    an_new = ~(ONE << nxt_idx);
  end

  // Digit step, frame latch and guard-interval sequencing
  always_comb begin
    idx_d     = idx_q;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    gcnt_d    = gcnt_q;
    seg_d     = seg_q;
    seg_dp_d  = seg_dp_q;
    an_d      = an_q;
    frame_d   = 1'b0;
    if (rise_q) begin
      idx_d    = nxt_idx;
      seg_d    = seg_new;
      seg_dp_d = ~act_dp[nxt_idx];
      gcnt_d   = GUARD_L;
      an_d     = (GUARD == 0) ? an_new : '1;
      if (wrap) begin
        sh_data_d = DATA;
        sh_dp_d   = DP;
        frame_d   = 1'b1;
      end
    end else if (gcnt_q != 4'd0) begin
      gcnt_d = gcnt_q - 4'd1;
      // Enable the anode on the same edge the counter reaches zero.
      if (gcnt_q == 4'd1) an_d = ~(ONE << idx_q);
    end
  end

  // Display state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      gcnt_q    <= '0;
      seg_q     <= '1;
      seg_dp_q  <= 1'b1;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      gcnt_q    <= gcnt_d;
      seg_q     <= seg_d;
      seg_dp_q  <= seg_dp_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign SEG    = seg_q;
  assign SEG_DP = seg_dp_q;
  assign AN     = an_q;
  assign FRAME  = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner: a GUARD=2 instance and a GUARD=0 instance
// share stimulus; a frame-level model queues each expected digit display.
module tb_seg7_scanner;
  localparam int D = 4;
  localparam int G = 2;

  logic        CLK = 1'b0;
  logic        RST, TICK;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic [6:0]  seg_a, seg_b;
  logic        sdp_a, sdp_b, fr_a, fr_b;
  logic [3:0]  an_a, an_b;

  seg7_scanner #(.DIGITS(D), .GUARD(G)) u_dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .DATA(DATA), .DP(DP),
    .SEG(seg_a), .SEG_DP(sdp_a), .AN(an_a), .FRAME(fr_a));

  seg7_scanner #(.DIGITS(D), .GUARD(0)) u_dut_g0 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .DATA(DATA), .DP(DP),
    .SEG(seg_b), .SEG_DP(sdp_b), .AN(an_b), .FRAME(fr_b));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       sdp;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   qfa[$];
  int   qfb[$];

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Frame-level model state
  int          m_idx = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // One scan step as seen from outside: next digit, frame latch at wrap.
  task automatic model_step(input bit show);
    exp_t e;
    logic [3:0] nib;
    bit wrapped;
    wrapped = (m_idx == D - 1);
    if (wrapped) begin
      m_idx  = 0;
      m_data = DATA;
      m_dp   = DP;
    end else begin
      m_idx++;
    end
    nib   = 4'((m_data >> (4 * m_idx)) & 16'hF);
    e.seg = segtab[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (m_idx > 0 && (m_data >> (4 * m_idx)) == 16'h0 && !m_dp[m_idx]) e.seg = 7'h7F;
`endif
    e.an  = ~(4'b0001 << m_idx);
    e.sdp = ~m_dp[m_idx];
    e.due = cyc + 4 + G;
    if (show) qa.push_back(e);
    e.due = cyc + 4;
    qb.push_back(e);
    if (wrapped) begin
      qfa.push_back(cyc + 4);
      qfb.push_back(cyc + 4);
    end
  endtask

  // Called at a negedge: TICK high for h cycles then low for l cycles.
  task automatic pulse(input int h, input int l, input bit newdata, input bit show);
    if (newdata) begin
      DATA = 16'($urandom);
      DP   = 4'($urandom);
    end
    TICK = 1'b1;
    model_step(show);
    repeat (h) @(negedge CLK);
    TICK = 1'b0;
    repeat (l) @(negedge CLK);
  endtask

  // Monitor for the guarded instance: each anode activation pops one entry.
  logic [3:0] pa = 4'hF;
  always @(negedge CLK) begin
    if (!RST) begin
      if (an_a != pa && an_a != 4'hF) begin
        if (qa.size() == 0) flag("an_a_extra");
        else begin
          exp_t e;
          e = qa.pop_front();
          chk("an_a", 32'(an_a), 32'(e.an));
          chk("seg_a", 32'(seg_a), 32'(e.seg));
          chk("segdp_a", 32'(sdp_a), 32'(e.sdp));
          chk("lat_a", cyc, e.due);
        end
      end
      if (fr_a) begin
        if (qfa.size() == 0) flag("frame_a_extra");
        else chk("frame_a", cyc, qfa.pop_front());
      end
    end
    pa = an_a;
  end

  // Monitor for the GUARD=0 instance
  logic [3:0] pb = 4'hF;
  always @(negedge CLK) begin
    if (!RST) begin
      if (an_b != pb && an_b != 4'hF) begin
        if (qb.size() == 0) flag("an_b_extra");
        else begin
          exp_t e;
          e = qb.pop_front();
          chk("an_b", 32'(an_b), 32'(e.an));
          chk("seg_b", 32'(seg_b), 32'(e.seg));
          chk("segdp_b", 32'(sdp_b), 32'(e.sdp));
          chk("lat_b", cyc, e.due);
        end
      end
      if (fr_b) begin
        if (qfb.size() == 0) flag("frame_b_extra");
        else chk("frame_b", cyc, qfb.pop_front());
      end
    end
    pb = an_b;
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_an"}, 32'(an_a), 32'hF);
    chk({nm, "_seg"}, 32'(seg_a), 32'h7F);
    chk({nm, "_segdp"}, 32'(sdp_a), 32'h1);
    chk({nm, "_frame"}, 32'(fr_a), 32'h0);
    chk({nm, "_an_g0"}, 32'(an_b), 32'hF);
    chk({nm, "_seg_g0"}, 32'(seg_b), 32'h7F);
  endtask

  initial begin
    RST  = 1'b1;
    TICK = 1'b0;
    DATA = '0;
    DP   = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Idle after reset: nothing lights and no frame pulse
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk_reset_vals("idle");
    end

    // Fixed word 1234, two full frames
    DATA = 16'h1234;
    DP   = 4'h0;
    for (int i = 0; i < 8; i++) pulse(2, 6, 1'b0, 1'b1);

    // Frame coherence: 0000 latched, FFFF applied mid-frame
    DATA = 16'h0000;
    while (m_idx != D - 1) pulse(2, 6, 1'b0, 1'b1);
    pulse(2, 6, 1'b0, 1'b1);
    DATA = 16'hFFFF;
    for (int i = 0; i < 7; i++) pulse(3, 5, 1'b0, 1'b1);

    // Long TICK high gives a single step
    pulse(50, 6, 1'b0, 1'b1);

    // Decimal point on digit 2
    DP = 4'b0100;
    while (m_idx != D - 1) pulse(2, 6, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pulse(2, 6, 1'b0, 1'b1);

    // Leading-zero word
    DATA = 16'h0042;
    DP   = 4'h0;
    while (m_idx != D - 1) pulse(2, 6, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pulse(2, 6, 1'b0, 1'b1);

    // A second rise inside the guard interval supersedes the first digit
    pulse(1, 1, 1'b0, 1'b0);
    pulse(2, 6, 1'b0, 1'b1);

    // Randomised scan with data updates at random steps
    for (int i = 0; i < 60; i++) begin
      pulse(int'($urandom_range(1, 8)), int'($urandom_range(G + 3, G + 8)),
            1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset in the middle of a step
    TICK = 1'b1;
    repeat (2) @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("midrst");
    qa.delete();
    qb.delete();
    qfa.delete();
    qfb.delete();
    m_idx  = 0;
    m_data = '0;
    m_dp   = '0;
    TICK   = 1'b0;
    @(negedge CLK);
    chk_reset_vals("inrst");
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk_reset_vals("postrst");

    DATA = 16'hA5C3;
    DP   = 4'b1001;
    for (int i = 0; i < 8; i++) pulse(2, 6, 1'b0, 1'b1);

    // Drain outstanding expectations with a bounded wait
    begin
      int n;
      n = 0;
      while ((qa.size() + qb.size() + qfa.size() + qfb.size()) != 0 && n < 100) begin
        @(negedge CLK);
        n++;
      end
      if ((qa.size() + qb.size() + qfa.size() + qfb.size()) != 0) flag("drain_timeout");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
